discr_scaler_1b: RTL and testbench

Single-channel discriminator scaler sitting directly downstream of the 1-bit inhibit generator. It consumes that stage's delayed discriminator bit and inhibit flag. It counts accepted rising edges, inhibited rising edges and inhibited (dead) cycles over contiguous, programmable gate windows. At the end of each window it latches the totals into output registers for slow-control readout and strobes a valid pulse.

---
 rtl/discr_scaler_1b_pkg.sv | 13 +
 rtl/discr_scaler_1b_if.sv | 28 ++
 rtl/discr_scaler_1b_sat_counter.sv | 35 +++
 rtl/posedge_detector.sv | 19 +
 rtl/discr_scaler_1b.sv | 107 ++++++++++
 tb/tb_discr_scaler_1b.sv | 161 ++++++++++++++++
 6 files changed

// File: rtl/discr_scaler_1b_pkg.sv
// discr_scaler_pkg: shared types and default widths for the discriminator scaler.
//   state_t          - 2-bit FSM encoding (S_IDLE / S_COUNT)
//   DEF_CNT_WIDTH    - default hit counter width
//   DEF_PERIOD_WIDTH - default window length / dead counter width
package discr_scaler_pkg;
  localparam int DEF_CNT_WIDTH    = 24;
  localparam int DEF_PERIOD_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1
  } state_t;
endpackage

// File: rtl/discr_scaler_1b_if.sv
// discr_scaler_1b_if: control, discriminator input and readout bundle.
//   master: drives en/period/bits_in/inhibit_bits, receives counters + strobe
//   slave : the scaler itself
interface discr_scaler_1b_if
  import discr_scaler_pkg::*;
#(
  parameter int P_CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int P_PERIOD_WIDTH = DEF_PERIOD_WIDTH
);
  logic                      en;
  logic [P_PERIOD_WIDTH-1:0] period;
  logic                      bits_in;
  logic                      inhibit_bits;
  logic [P_CNT_WIDTH-1:0]    hit_cnt;
  logic [P_CNT_WIDTH-1:0]    inhib_hit_cnt;
  logic [P_PERIOD_WIDTH-1:0] dead_cnt;
  logic                      cnt_ovf;
  logic                      cnt_valid;

  modport master (
    output en, period, bits_in, inhibit_bits,
    input  hit_cnt, inhib_hit_cnt, dead_cnt, cnt_ovf, cnt_valid
  );
  modport slave (
    input  en, period, bits_in, inhibit_bits,
    output hit_cnt, inhib_hit_cnt, dead_cnt, cnt_ovf, cnt_valid
  );
endinterface

// File: rtl/discr_scaler_1b_sat_counter.sv
// discr_scaler_1b_sat_counter: saturating accumulator with sticky overflow.
//   clr_i     - synchronous clear (wins over inc_i)
//   inc_i     - count request
//   nxt_o     - value including this cycle's increment, used to latch the
//               final cycle of a window in the same edge as the clear
//   ovf_nxt_o - sticky overflow including this cycle (set when an increment
//               is dropped because the counter is already all-ones)
module discr_scaler_1b_sat_counter #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             ovf_nxt_o
);
  logic [WIDTH-1:0] cnt_q;
  logic             ovf_q;
  logic             full;

  assign full      = &cnt_q;
  assign nxt_o     = (inc_i && !full) ? cnt_q + WIDTH'(1) : cnt_q;
  assign ovf_nxt_o = ovf_q | (inc_i & full);

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= nxt_o;
      ovf_q <= ovf_nxt_o;
    end
  end
endmodule

// File: rtl/posedge_detector.sv
// posedge_detector: single-cycle pulse when sig_i is high and was low the
// cycle before. History register resets to 0, so a level already high out
// of reset counts as an edge.
//   clk, rst_n (sync, active low), sig_i -> pulse_o (combinational)
module posedge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic pulse_o
);
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= sig_i;
  end

  assign pulse_o = sig_i & ~prev_q;
endmodule

// File: rtl/discr_scaler_1b.sv
// discr_scaler_1b: counts accepted edges, inhibited edges and inhibited
// cycles over back-to-back windows of `period` cycles, latching totals and
// strobing cnt_valid at each window close.
//   clk, rst_n (sync, active low)
//   bus (slave): en, period, bits_in, inhibit_bits in;
//                hit_cnt, inhib_hit_cnt, dead_cnt, cnt_ovf, cnt_valid out
module discr_scaler_1b
  import discr_scaler_pkg::*;
#(
  parameter int P_CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int P_PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  discr_scaler_1b_if.slave    bus
);
  state_t                    state_q, state_d;
  logic [P_PERIOD_WIDTH-1:0] period_l_q, tick_q, dead_q, dead_nxt;
  logic [P_CNT_WIDTH-1:0]    hit_out_q, inh_out_q, hit_nxt, inh_nxt;
  logic [P_PERIOD_WIDTH-1:0] dead_out_q;
  logic                      ovf_out_q, valid_q;
  logic                      bit_edge, ovf_hit, ovf_inh;
  logic                      start, run, last, clr;

  posedge_detector u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_i   (bus.bits_in),
    .pulse_o (bit_edge)
  );

  discr_scaler_1b_sat_counter #(.WIDTH(P_CNT_WIDTH)) u_hit (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .inc_i     (run & bit_edge & ~bus.inhibit_bits),
    .nxt_o     (hit_nxt),
    .ovf_nxt_o (ovf_hit)
  );

  discr_scaler_1b_sat_counter #(.WIDTH(P_CNT_WIDTH)) u_inh (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .inc_i     (run & bit_edge & bus.inhibit_bits),
    .nxt_o     (inh_nxt),
    .ovf_nxt_o (ovf_inh)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_COUNT : S_IDLE;
      S_COUNT: state_d = (!bus.en || (last && bus.period == '0)) ? S_IDLE : S_COUNT;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs. Accumulators are cleared whenever not counting and on the
  // closing cycle (after the final contribution is latched via *_nxt).
  always_comb begin
    start = (state_q == S_IDLE) && bus.en && (bus.period != '0);
    run   = (state_q == S_COUNT) && bus.en;
    last  = run && (tick_q == period_l_q - P_PERIOD_WIDTH'(1));
    clr   = !run || last;
  end

  // acc_dead is bounded by the window length, so a plain adder suffices.
  assign dead_nxt = dead_q + P_PERIOD_WIDTH'(bus.inhibit_bits);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_l_q <= '0;
      tick_q     <= '0;
      dead_q     <= '0;
      hit_out_q  <= '0;
      inh_out_q  <= '0;
      dead_out_q <= '0;
      ovf_out_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      if (start || last) period_l_q <= bus.period;
      tick_q  <= (run && !last) ? tick_q + P_PERIOD_WIDTH'(1) : '0;
      dead_q  <= clr ? '0 : dead_nxt;
      valid_q <= last;
      if (last) begin
        hit_out_q  <= hit_nxt;
        inh_out_q  <= inh_nxt;
        dead_out_q <= dead_nxt;
        ovf_out_q  <= ovf_hit | ovf_inh;
      end
    end
  end

  assign bus.hit_cnt       = hit_out_q;
  assign bus.inhib_hit_cnt = inh_out_q;
  assign bus.dead_cnt      = dead_out_q;
  assign bus.cnt_ovf       = ovf_out_q;
  assign bus.cnt_valid     = valid_q;
endmodule

// File: tb/tb_discr_scaler_1b.sv
module tb_discr_scaler_1b;
  localparam int CW = 4;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  discr_scaler_1b_if #(.P_CNT_WIDTH(CW), .P_PERIOD_WIDTH(PW)) bus ();

  discr_scaler_1b #(.P_CNT_WIDTH(CW), .P_PERIOD_WIDTH(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int hit;
    int inh;
    int dead;
    int ovf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every valid strobe must match the oldest expected window.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.cnt_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0 at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("hit_cnt",       bus.hit_cnt,       e.hit);
        chk("inhib_hit_cnt", bus.inhib_hit_cnt, e.inh);
        chk("dead_cnt",      bus.dead_cnt,      e.dead);
        chk("cnt_ovf",       bus.cnt_ovf,       e.ovf);
      end
    end
  end

  task automatic cyc(input logic b, input logic i);
    bus.bits_in      = b;
    bus.inhibit_bits = i;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int p);
    bus.en     = 1'b1;
    bus.period = p;
    cyc(1'b0, 1'b0);
  endtask

  task automatic stop();
    bus.en = 1'b0;
    cyc(1'b0, 1'b0);
  endtask

  // One window of len cycles; bit k of the masks is the input in window cycle k.
  task automatic run_win(input int len, input logic [127:0] bm, input logic [127:0] im,
                         input int eh, input int ei, input int ed, input int eo,
                         input int chg_at = -1, input int newp = 0);
    exp_t e;
    e.hit = eh; e.inh = ei; e.dead = ed; e.ovf = eo;
    q.push_back(e);
    for (int k = 0; k < len; k++) begin
      if (k == chg_at) bus.period = newp;
      cyc(bm[k], im[k]);
      if (k < len - 1) chk("valid_mid_window", bus.cnt_valid, 0);
    end
    chk("valid_at_close", bus.cnt_valid, 1);
  endtask

  task automatic chk_outs(input string tag, input int h, input int i, input int d, input int o);
    chk({tag, "_hit"},   bus.hit_cnt,       h);
    chk({tag, "_inh"},   bus.inhib_hit_cnt, i);
    chk({tag, "_dead"},  bus.dead_cnt,      d);
    chk({tag, "_ovf"},   bus.cnt_ovf,       o);
    chk({tag, "_valid"}, bus.cnt_valid,     0);
  endtask

  initial begin
    bus.en = 1'b0; bus.period = '0; bus.bits_in = 1'b0; bus.inhibit_bits = 1'b0;
    rst_n = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    chk_outs("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);

    // Isolated pulses, edge on last cycle, level held across a boundary
    start(10);
    run_win(10, 128'h92,  128'h0, 3, 0, 0, 0);
    run_win(10, 128'h200, 128'h0, 1, 0, 0, 0);
    run_win(10, 128'h7,   128'h0, 0, 0, 0, 0);
    stop();

    // period=1: one window per cycle, strobe continuous
    start(1);
    for (int n = 0; n < 3; n++) begin
      run_win(1, 128'h1, 128'h0, 1, 0, 0, 0);
      run_win(1, 128'h0, 128'h0, 0, 0, 0, 0);
    end
    stop();

    // Inhibit window covering two edges plus one accepted edge outside it
    start(20);
    run_win(20, 128'h8240, 128'h7E0, 1, 2, 6, 0);
    stop();

    // Abort at window cycle 5: no strobe, outputs held, next window fresh
    start(10);
    cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b1); cyc(1'b0, 1'b0);
    bus.en = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    chk_outs("abort_hold", 1, 2, 6, 0);
    start(10);
    run_win(10, 128'h1, 128'h0, 1, 0, 0, 0);
    stop();

    // Saturation at 4 bits, then an empty window clears overflow
    start(100);
    run_win(100, 128'h55_5555_5555, 128'h0, 15, 0, 0, 1);
    run_win(100, 128'h0,            128'h0,  0, 0, 0, 0);
    stop();

    // Period 10 -> 4 mid-window takes effect at the next boundary
    start(10);
    run_win(10, 128'h200, 128'h0, 1, 0, 0, 0, 3, 4);
    run_win(4,  128'h4,   128'h0, 1, 0, 0, 0);
    run_win(4,  128'h0,   128'h2, 0, 0, 1, 0);
    stop();

    // Reset at window cycle 7
    start(10);
    for (int k = 0; k < 7; k++) cyc(k == 2, k == 4);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    chk_outs("mid_reset", 0, 0, 0, 0);
    bus.en = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);
    chk("pending_expected", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
